min_cost_arbiter: RTL



---
 rtl/min_cost_arbiter_pkg.sv | 21 ++
 rtl/min_cost_arbiter_min4_select.sv | 43 ++++
 rtl/min_cost_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/min_cost_arbiter_pkg.sv
// Shared types and constants for the min-cost arbiter.
// Cost-slice helper extracts one requester's cost from the packed bus.
package min_cost_arbiter_pkg;

    localparam int NREQ = 4;
    localparam int CW   = 3;
    localparam int IDXW = 2;
    localparam int HOLD_W = 4;
    localparam logic [CW-1:0] AGE_MAX = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [CW-1:0] cost_slice(input logic [NREQ*CW-1:0] cost_bus,
                                                  input int unsigned idx);
        return cost_bus[idx*CW +: CW];
    endfunction

endpackage

// File: rtl/min_cost_arbiter_min4_select.sv
// Combinational 4-input minimum-index selector; zero latency, no flow control.
// Lowest index wins when keys are equal.
module min4_select
    import min_cost_arbiter_pkg::*;
(
    input  logic [CW:0]     key0_i,
    input  logic [CW:0]     key1_i,
    input  logic [CW:0]     key2_i,
    input  logic [CW:0]     key3_i,
    output logic [IDXW-1:0] idx_o
);

    logic [CW:0]     min01;
    logic [CW:0]     min23;
    logic [IDXW-1:0] idx01;
    logic [IDXW-1:0] idx23;

    always_comb begin
        // "<=" keeps the left (lower) index on ties at every level of the tree
        if (key0_i <= key1_i) begin
            min01 = key0_i;
            idx01 = 2'd0;
        end else begin
            min01 = key1_i;
            idx01 = 2'd1;
        end

        if (key2_i <= key3_i) begin
            min23 = key2_i;
            idx23 = 2'd2;
        end else begin
            min23 = key3_i;
            idx23 = 2'd3;
        end

        if (min01 <= min23) begin
            idx_o = idx01;
        end else begin
            idx_o = idx23;
        end
    end

endmodule

// File: rtl/min_cost_arbiter.sv
// Lowest effective-cost (cost - age) arbiter for 4 requesters with hold timeout.
// Grant latency 1 cycle; grant held until done, request drop, or HOLD_MAX cycles.
module min_cost_arbiter
    import min_cost_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   cost,
    input  logic                 done,
    output logic [NREQ-1:0]      gnt,
    output logic                 gnt_valid,
    output logic [IDXW-1:0]      gnt_idx,
    output logic                 timeout
);

    state_t                     state_q, state_d;
    logic [NREQ-1:0]            gnt_q, gnt_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic                       timeout_q, timeout_d;
    logic [NREQ-1:0][CW-1:0]    age_q, age_d;

    logic [NREQ-1:0][CW:0]      keys;
    logic [IDXW-1:0]            sel_idx;
    logic                       hold_expired;
    logic                       release_now;

    // Non-requesters get MSB set so they lose against any real cost
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            logic [CW-1:0] c_v;
            logic [CW-1:0] eff_v;
            c_v   = cost_slice(cost, i);
            eff_v = (c_v > age_q[i]) ? (c_v - age_q[i]) : '0;
            keys[i] = req[i] ? {1'b0, eff_v} : {1'b1, {CW{1'b0}}};
        end
    end

    min4_select u_min4_select (
        .key0_i (keys[0]),
        .key1_i (keys[1]),
        .key2_i (keys[2]),
        .key3_i (keys[3]),
        .idx_o  (sel_idx)
    );

    assign hold_expired = (hold_q == HOLD_W'(HOLD_MAX));
    assign release_now  = done || !req[idx_q] || hold_expired;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        age_d     = age_q;

        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
                age_d[i] = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d        = GRANT;
                    idx_d          = sel_idx;
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    hold_d         = HOLD_W'(1);
                    for (int i = 0; i < NREQ; i++) begin
                        if (req[i]) begin
                            if (IDXW'(i) == sel_idx) begin
                                age_d[i] = '0;
                            end else if (age_q[i] != AGE_MAX) begin
                                age_d[i] = age_q[i] + 3'd1;
                            end
                        end
                    end
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    idx_d     = '0;
                    hold_d    = '0;
                    // done or a dropped request override the timeout indication
                    timeout_d = hold_expired && !done && req[idx_q];
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            age_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            age_q     <= age_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;

endmodule
